// File: rtl/alu_operand_sequencer.sv
// Operand front-end for alu_ip: collects (A, B, sel) bytes, holds them on the ALU
// inputs for ALU_LAT cycles, then offers the captured result over valid/ready.
module alu_operand_sequencer #(
    parameter int unsigned ALU_LAT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       alu_a,
    output logic [7:0]       alu_b,
    output logic [2:0]       alu_sel,
    input  logic [7:0]       alu_c,
    input  logic             alu_z,
    output logic [7:0]       res_data,
    output logic             res_z,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             sel_err,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [2:0] {
        GET_A,
        GET_B,
        GET_SEL,
        WAIT,
        HOLD
    } state_t;

    localparam logic [2:0] LAT3 = 3'(ALU_LAT);

    state_t     state;
    state_t     state_nx;
    logic [2:0] wcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= GET_A;
        end else begin
            state <= state_nx;
        end
    end

    // Handshake outputs depend on state only, never on in_valid/res_ready.
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        res_valid = 1'b0;
        case (state)
            GET_A: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = GET_B;
            end
            GET_B: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = GET_SEL;
            end
            GET_SEL: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = WAIT;
            end
            WAIT: begin
                if (wcnt == 3'd0) state_nx = HOLD;
            end
            HOLD: begin
                res_valid = 1'b1;
                if (res_ready) state_nx = GET_A;
            end
            default: state_nx = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_sel  <= '0;
            res_data <= '0;
            res_z    <= 1'b0;
            sel_err  <= 1'b0;
            op_count <= '0;
            wcnt     <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (in_valid) alu_a <= in_data;
                end
                GET_B: begin
                    if (in_valid) alu_b <= in_data;
                end
                GET_SEL: begin
                    if (in_valid) begin
                        // Out-of-range sel is flagged but still executed truncated.
                        alu_sel <= in_data[2:0];
                        if (|in_data[7:3]) sel_err <= 1'b1;
                        wcnt <= LAT3;
                    end
                end
                WAIT: begin
                    if (wcnt != 3'd0) begin
                        wcnt <= wcnt - 3'd1;
                    end else begin
                        res_data <= alu_c;
                        res_z    <= alu_z;
                    end
                end
                HOLD: begin
                    if (res_ready) op_count <= op_count + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Scoreboard bench for alu_operand_sequencer with a latency-aware ALU model that
// outputs garbage until its operands have been stable for ALU_LAT cycles.
module tb_alu_operand_sequencer;

    localparam int unsigned LAT = 3;
    localparam int unsigned CW  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    alu_a, alu_b, alu_c;
    logic [2:0]    alu_sel;
    logic          alu_z;
    logic [7:0]    res_data;
    logic          res_z, res_valid;
    logic          res_ready = 1'b0;
    logic          sel_err;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_operand_sequencer #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_c(alu_c), .alu_z(alu_z),
        .res_data(res_data), .res_z(res_z), .res_valid(res_valid), .res_ready(res_ready),
        .sel_err(sel_err), .op_count(op_count)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        case (s)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return a;
            3'd6: return b;
            default: return ~a;
        endcase
    endfunction

    // ALU model: result is only trustworthy LAT edges after the operands last changed.
    logic [18:0] last_ops = '0;
    int unsigned stab = 0;
    logic        alu_ok;
    logic [7:0]  alu_res;

    always @(posedge clk) begin
        if ({alu_a, alu_b, alu_sel} != last_ops) begin
            last_ops <= {alu_a, alu_b, alu_sel};
            stab     <= 1;
        end else if (stab < 7) begin
            stab <= stab + 1;
        end
    end

    always_comb begin
        alu_res = alu_fn(alu_a, alu_b, alu_sel);
        alu_ok  = (LAT == 0) || (({alu_a, alu_b, alu_sel} == last_ops) && (stab >= LAT));
        alu_c   = alu_ok ? alu_res : (alu_res ^ 8'h5A);
        alu_z   = alu_ok ? (alu_res == 8'h00) : (alu_res != 8'h00);
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [7:0] c;
        logic       z;
    } exp_t;

    exp_t        q[$];
    logic        err_model = 1'b0;
    int unsigned delivered = 0;
    time         acc_time = 0;
    time         sel_time = 0;
    bit          quiet = 1'b1;
    bit          prev_valid = 1'b0;
    logic [7:0]  held_c = '0;
    logic        held_z = 1'b0;
    int          rr_mode = 1;

    // Downstream ready: changes just after posedge so it is settled by the negedge monitor.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rr_mode)
                0:       res_ready = ($urandom_range(2) != 0);
                1:       res_ready = 1'b1;
                default: res_ready = 1'b0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (quiet) begin
            prev_valid = 1'b0;
        end else begin
            chk("op_count", 32'(op_count), 32'(delivered % (1 << CW)));
            chk("sel_err", 32'(sel_err), 32'(err_model));
            if (res_valid) begin
                chk("in_ready_in_hold", 32'(in_ready), 32'd0);
                if (!prev_valid) begin
                    if (q.size() == 0) begin
                        chk("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        exp_t e;
                        e = q.pop_front();
                        chk("res_data", 32'(res_data), 32'(e.c));
                        chk("res_z", 32'(res_z), 32'(e.z));
                        chk("latency", 32'($time - sel_time), 32'((LAT + 1) * 10 + 5));
                    end
                    held_c = res_data;
                    held_z = res_z;
                end else begin
                    chk("res_data_stable", 32'(res_data), 32'(held_c));
                    chk("res_z_stable", 32'(res_z), 32'(held_z));
                end
                if (res_ready) delivered++;
            end
            prev_valid = res_valid;
        end
    end

    task automatic send_byte(input logic [7:0] b, input int idles);
        int n;
        repeat (idles) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
        @(negedge clk);
        in_data  = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        acc_time = $time;
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
    endtask

    task automatic send_trip(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s, input int idles);
        exp_t e;
        send_byte(a, idles);
        send_byte(b, idles);
        send_byte(s, idles);
        sel_time  = acc_time;
        err_model = err_model | (s[7:3] != 5'd0);
        e.c = alu_fn(a, b, s[2:0]);
        e.z = (e.c == 8'h00);
        q.push_back(e);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || res_valid) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        quiet = 1'b1;
        rst   = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_alu_a", 32'(alu_a), 32'd0);
        chk("rst_alu_b", 32'(alu_b), 32'd0);
        chk("rst_alu_sel", 32'(alu_sel), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_z", 32'(res_z), 32'd0);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_op_count", 32'(op_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        q.delete();
        delivered = 0;
        err_model = 1'b0;
        @(posedge clk);
        #1;
        quiet = 1'b0;
    endtask

    function automatic logic [7:0] rand_sel();
        return ($urandom_range(7) == 0) ? 8'($urandom) : 8'($urandom_range(7));
    endfunction

    initial begin
        int n;
        do_reset();

        // Basic add
        rr_mode = 1;
        send_trip(8'd5, 8'd3, 8'd0, 0);
        chk("basic_alu_a", 32'(alu_a), 32'd5);
        chk("basic_alu_b", 32'(alu_b), 32'd3);
        chk("basic_alu_sel", 32'(alu_sel), 32'd0);
        drain();
        chk("basic_op_count", 32'(op_count), 32'd1);

        // Signed wrap and zero flag
        send_trip(8'd127, 8'd1, 8'd0, 0);
        send_trip(8'hF9, 8'hF9, 8'd1, 0);
        drain();

        // Input stalls between bytes
        send_trip(8'd20, 8'd7, 8'd1, 2);
        drain();

        // Output backpressure
        rr_mode = 2;
        send_trip(8'd9, 8'd12, 8'd4, 0);
        n = 0;
        while (!res_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_res_valid_seen", 32'(res_valid), 32'd1);
        repeat (10) begin
            @(negedge clk);
            chk("bp_res_valid", 32'(res_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
        end
        rr_mode = 1;
        drain();

        // Sticky sel_err
        send_trip(8'd10, 8'd4, 8'h09, 0);
        chk("err_alu_sel", 32'(alu_sel), 32'd1);
        chk("err_sel_err", 32'(sel_err), 32'd1);
        drain();
        send_trip(8'd1, 8'd2, 8'd0, 0);
        drain();
        chk("err_sticky", 32'(sel_err), 32'd1);

        // Reset with a partial triplet pending
        send_byte(8'd33, 0);
        send_byte(8'd44, 0);
        do_reset();
        send_trip(8'd2, 8'd2, 8'd0, 0);
        drain();
        chk("post_rst_op_count", 32'(op_count), 32'd1);

        // Counter wrap at 4 bits
        do_reset();
        for (int i = 1; i <= 17; i++) begin
            send_trip(8'($urandom), 8'($urandom), 8'($urandom_range(7)), 0);
            drain();
            if (i >= 15) chk("wrap_op_count", 32'(op_count), 32'(i % 16));
        end

        // Random traffic with random stalls and backpressure
        rr_mode = 0;
        for (int i = 0; i < 40; i++) begin
            send_trip(8'($urandom), 8'($urandom), rand_sel(), $urandom_range(2));
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_operand_sequencer.md
# alu_operand_sequencer

Front-end stage for `alu_ip`. It accepts a byte stream of operand triplets (A, B, sel), in the same order as our ALU stimulus data files, over a valid/ready handshake. It drives the held operands onto the ALU inputs and waits a programmable ALU latency. It then captures C and Z into a result register offered downstream over valid/ready. Exactly one operation is in flight at a time.

## Interface
- `ALU_LAT`, default 0: cycles from operands stable at ALU inputs to `alu_c`/`alu_z` valid. 0 means the ALU is combinational. Legal range is 0–7.
- `CNT_W`, default 16: width of `op_count`.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_data`  in  8  stream byte: A, then B, then sel (in that order).
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  the block accepts `in_data` this cycle.
- `alu_a`  out  8  signed operand A to `alu_ip.A`.
- `alu_b`  out  8  signed operand B to `alu_ip.B`.
- `alu_sel`  out  3  op select to `alu_ip.sel`.
- `alu_c`  in  8  signed result from `alu_ip.C`.
- `alu_z`  in  1  zero flag from `alu_ip.Z`.
- `res_data`  out  8  captured signed result.
- `res_z`  out  1  captured zero flag.
- `res_valid`  out  1  result available.
- `res_ready`  in  1  downstream takes the result.
- `sel_err`  out  1  sticky flag: a sel byte arrived with bits [7:3] non-zero.
- `op_count`  out  CNT_W  number of results delivered; wraps at all-ones to 0.

## Operation
FSM states: GET_A, GET_B, GET_SEL, WAIT, HOLD.
- **GET_A:** `in_ready`=1. When `in_valid`, register A and go to GET_B.
- **GET_B:** `in_ready`=1. When `in_valid`, register B and go to GET_SEL.
- **GET_SEL:** `in_ready`=1. When `in_valid`:
  - register sel = `in_data`[2:0];
  - if `in_data`[7:3] ≠ 0, set `sel_err`; the operation still executes with the truncated sel;
  - load the wait counter with `ALU_LAT` and go to WAIT.
- **WAIT:** `in_ready`=0.
  - If the counter ≠ 0, decrement it.
  - If the counter = 0, capture `alu_c` into `res_data` and `alu_z` into `res_z`, then go to HOLD.
- **HOLD:** `res_valid`=1 and `in_ready`=0. When `res_ready`, increment `op_count` and go to GET_A.

Output and datapath rules:
- `alu_a`, `alu_b`, `alu_sel` are direct register outputs. They change only on an accepted byte of the matching kind and stay stable through WAIT and HOLD.
- `in_ready` and `res_valid` are decoded from the state only. There is no combinational path from `in_valid` or `res_ready`.
- There is no arithmetic on the data. Operands and results pass through bit-exact; signedness is carried by interpretation only.
- `sel_err` clears only on `rst`.

## Timing
- **Reset values (cycle after an edge with `rst`=1):**
  - state GET_A;
  - `alu_a`, `alu_b`, `res_data`, `op_count` = 0; `alu_sel` = 0;
  - `res_z`, `res_valid`, `sel_err` = 0;
  - `in_ready` = 1.
- **Reset mid-operation:** the partial triplet is discarded and any pending result is dropped (`res_valid` is 0 the next cycle). `op_count` is not incremented.
- **Latency:** the sel byte is accepted at edge T. C is sampled at edge T+1+`ALU_LAT`, and `res_valid` rises in the cycle after that edge.
- **Throughput:** minimum `ALU_LAT`+5 cycles per operation with `in_valid` and `res_ready` held high.
- **Input stalls:** `in_valid` low in a GET state holds the state; no byte is lost or duplicated.
- **Output backpressure:** `res_ready` low holds HOLD indefinitely with `res_data`/`res_z` stable.
- **Early `res_ready`:** `res_ready` high before HOLD has no effect.
- **Early bytes:** `in_valid` during WAIT/HOLD is not accepted; the upstream source must hold the byte.

## Test plan
In the bench, `alu_c`/`alu_z` come from a model: sel=0 gives A+B, sel=1 gives A−B (8-bit wrap), Z = (C==0).
- **Basic op, `ALU_LAT`=0:** stream 5, 3, 0 back-to-back with `res_ready`=1.
  - `alu_a`=5, `alu_b`=3, `alu_sel`=0;
  - `res_data`=8, `res_z`=0, `res_valid` rises one cycle after the sel edge;
  - `op_count`=1.
- **Wrap and zero flag:** stream 127, 1, 0 → `res_data`=−128. Then stream −7, −7, 1 → `res_data`=0, `res_z`=1.
- **`ALU_LAT`=3 with stalls and backpressure:**
  - insert 2 idle `in_valid` cycles between bytes → `res_valid` rises 4 cycles after the sel-accept edge (sel-accept edge is edge T; C is sampled at edge T+4 = T+1+`ALU_LAT`; `res_valid` is high from the cycle following edge T+4).
  - hold `res_ready`=0 for 10 cycles → `res_valid` stays high, `res_data` stable, `in_ready`=0 throughout.
- **sel_err:** stream 10, 4, 0x09 → `alu_sel`=1, `res_data`=6, `sel_err`=1. The next clean triplet leaves `sel_err` at 1.
- **Reset mid-operation:** assert `rst` after A and B are accepted → all outputs at reset values next cycle. A new triplet 2, 2, 0 then yields `res_data`=4 and `op_count`=1.
- **Counter wrap:** with `CNT_W`=4, run 17 operations → `op_count` reads 15 after op 15, 0 after op 16, 1 after op 17.
